// File: rtl/vga_text_fetch.sv
// 640x480@60 text-mode fetch: VRAM code -> font row -> pixels.
// 32x24 cells of 8x8 glyphs, each pixel doubled, centred in a border.
//
// Ports:
//   clk        pixel clock (also clocks the VRAM read port)
//   reset      asynchronous, active-high
//   vram_addr  registered VRAM read address; vram_q valid 1 clk later
//   font_addr  registered font ROM address {code[6:0], line}
//   font_q     glyph row, MSB leftmost; valid 1 clk after font_addr
//   hsync      active-low horizontal sync
//   vsync      active-low vertical sync
//   de         visible area
//   border     visible pixel outside the text window
//   pixel      text ink
//
// Every output describes the counter position of the previous cycle.
module vga_text_fetch #(
    parameter int COLS      = 32,
    parameter int ROWS      = 24,
    parameter int VRAM_BASE = 0,
    parameter int H_OFS     = 64,
    parameter int V_OFS     = 48
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_q,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_q,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        border,
    output logic        pixel
);

    localparam logic [9:0] H_END = 10'd799;
    localparam logic [9:0] V_END = 10'd524;
    localparam logic [9:0] WX0 = 10'(H_OFS);
    localparam logic [9:0] WX1 = 10'(H_OFS + 16 * COLS);
    localparam logic [9:0] WY0 = 10'(V_OFS);
    localparam logic [9:0] WY1 = 10'(V_OFS + 16 * ROWS);
    localparam logic [9:0] FX0 = 10'(H_OFS - 16);
    localparam logic [9:0] FX1 = 10'(H_OFS + 16 * COLS - 16);
    localparam logic [12:0] BASE = 13'(VRAM_BASE);
    localparam logic [12:0] NCOL = 13'(COLS);

    logic [9:0] hc;
    logic [9:0] vc;

    logic [3:0] p;
    logic [5:0] col_f;
    logic [4:0] row;
    logic [2:0] line;
    logic [2:0] xb;
    logic       vwin;
    logic       win;
    logic       slot;
    logic       vis;

    // Fetch pipeline state
    logic       code7;
    logic [7:0] pat;
    logic       pinv;
    logic [7:0] shifter;
    logic       sinv;

    // Slot phase/column are taken relative to one cell before the window
    // so the fetch for column c completes just as column c is displayed.
    always_comb begin
        p     = 4'(hc - FX0);
        col_f = 6'((hc - FX0) >> 4);
        row   = 5'((vc - WY0) >> 4);
        line  = 3'((vc - WY0) >> 1);
        xb    = 3'((hc - WX0) >> 1);
        vwin  = (vc >= WY0) && (vc < WY1);
        win   = vwin && (hc >= WX0) && (hc < WX1);
        slot  = vwin && (hc >= FX0) && (hc < FX1);
        vis   = (hc < 10'd640) && (vc < 10'd480);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_END) begin
            hc <= '0;
            vc <= (vc == V_END) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            de     <= 1'b0;
            border <= 1'b0;
            pixel  <= 1'b0;
        end else begin
            hsync  <= !((hc >= 10'd656) && (hc <= 10'd751));
            vsync  <= !((vc >= 10'd490) && (vc <= 10'd491));
            de     <= vis;
            border <= vis && !win;
            // ~xb selects bit 7-x[2:0]: leftmost pixel is the MSB
            pixel  <= win && (shifter[~xb] ^ sinv);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_addr <= '0;
            font_addr <= '0;
            code7     <= 1'b0;
            pat       <= '0;
            pinv      <= 1'b0;
            shifter   <= '0;
            sinv      <= 1'b0;
        end else if (slot) begin
            case (p)
                4'd0: begin
                    vram_addr <= BASE + 13'(row) * NCOL + 13'(col_f);
                end
                4'd2: begin
                    code7     <= vram_q[7];
                    font_addr <= {vram_q[6:0], line};
                end
                4'd4: begin
                    pat  <= font_q;
                    pinv <= code7;
                end
                4'd15: begin
                    shifter <= pat;
                    sinv    <= pinv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Bench for vga_text_fetch: cycle-by-cycle reference model plus
// probe table and hand sequences. Uses a short V_OFS to stay fast.
module tb_vga_text_fetch;

    localparam int HO   = 64;
    localparam int VO   = 4;
    localparam int COLS = 32;
    localparam int ROWS = 24;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] vram_addr;
    logic [7:0]  vram_q;
    logic [9:0]  font_addr;
    logic [7:0]  font_q;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        border;
    logic        pixel;

    logic [7:0] vram [8192];
    logic [7:0] font [1024];

    int checks = 0;
    int failures = 0;
    int ch = 0;
    int cv = 0;
    logic [12:0] e_va = '0;
    logic [9:0]  e_fa = '0;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic de;
        logic bd;
        logic px;
    } vec_t;

    vec_t tab [28];

    vga_text_fetch #(
        .COLS(COLS),
        .ROWS(ROWS),
        .VRAM_BASE(BASE),
        .H_OFS(HO),
        .V_OFS(VO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vram_addr(vram_addr),
        .vram_q(vram_q),
        .font_addr(font_addr),
        .font_q(font_q),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .border(border),
        .pixel(pixel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vram_q <= vram[vram_addr];
        font_q <= font[font_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s h=%0d v=%0d got=%h want=%h",
                     name, ch, cv, act, exp);
        end
    endtask

    // {hsync, vsync, de, border, pixel} for screen position (h,v)
    function automatic logic [4:0] ref_vis(input int h, input int v);
        logic hs, vs, dv, win, px;
        logic [7:0] code, pt;
        int x, y;
        dv  = (h < 640) && (v < 480);
        hs  = !((h >= 656) && (h <= 751));
        vs  = !((v >= 490) && (v <= 491));
        win = (h >= HO) && (h < HO + 16 * COLS) &&
              (v >= VO) && (v < VO + 16 * ROWS);
        px  = 1'b0;
        if (win) begin
            x    = (h - HO) / 2;
            y    = (v - VO) / 2;
            code = vram[(BASE + (y / 8) * COLS + x / 8) % 8192];
            pt   = font[int'(code[6:0]) * 8 + y % 8];
            px   = pt[7 - x % 8] ^ code[7];
        end
        return {hs, vs, dv, dv && !win, px};
    endfunction

    task automatic step();
        int s, y, a;
        logic [4:0] v5;
        @(negedge clk);
        if (cv >= VO && cv < VO + 16 * ROWS &&
            ch >= HO - 16 && ch < HO + 16 * COLS - 16) begin
            s = ch - HO + 16;
            y = (cv - VO) / 2;
            a = (BASE + (y / 8) * COLS + s / 16) % 8192;
            if (s % 16 == 0) e_va = 13'(a);
            if (s % 16 == 2) e_fa = 10'(int'(vram[a][6:0]) * 8 + y % 8);
        end
        v5 = ref_vis(ch, cv);
        check("model",
              {4'd0, hsync, vsync, de, border, pixel, vram_addr, font_addr},
              {4'd0, v5, e_va, e_fa});
        ch++;
        if (ch == 800) begin
            ch = 0;
            cv = (cv == 524) ? 0 : cv + 1;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(ch == h && cv == v) && n < 90000) begin
            step();
            n++;
        end
        if (!(ch == h && cv == v)) begin
            checks++;
            failures++;
            $display("FAIL run_to h=%0d v=%0d not reached", h, v);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            run_to(tab[i].h, tab[i].v);
            step();
            check($sformatf("tab%0d", i),
                  {28'd0, hsync, de, border, pixel},
                  {28'd0, tab[i].hs, tab[i].de, tab[i].bd, tab[i].px});
        end
    endtask

    task automatic hold_reset();
        logic [31:0] rv;
        rv = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0, 10'd0};
        reset = 1'b1;
        #1;
        check("rst_async",
              {4'd0, hsync, vsync, de, border, pixel, vram_addr, font_addr},
              rv);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold",
                  {4'd0, hsync, vsync, de, border, pixel, vram_addr, font_addr},
                  rv);
        end
        reset = 1'b0;
        ch = 0;
        cv = 0;
        e_va = '0;
        e_fa = '0;
    endtask

    initial begin
        int n;

        tab[0]  = '{100, 2, 1, 1, 1, 0};
        tab[1]  = '{63,  4, 1, 1, 1, 0};
        tab[2]  = '{64,  4, 1, 1, 0, 1};
        tab[3]  = '{65,  4, 1, 1, 0, 1};
        tab[4]  = '{66,  4, 1, 1, 0, 0};
        tab[5]  = '{71,  4, 1, 1, 0, 0};
        tab[6]  = '{77,  4, 1, 1, 0, 0};
        tab[7]  = '{78,  4, 1, 1, 0, 1};
        tab[8]  = '{79,  4, 1, 1, 0, 1};
        tab[9]  = '{80,  4, 1, 1, 0, 0};
        tab[10] = '{639, 4, 1, 1, 1, 0};
        tab[11] = '{640, 4, 1, 0, 0, 0};
        tab[12] = '{655, 4, 1, 0, 0, 0};
        tab[13] = '{656, 4, 0, 0, 0, 0};
        tab[14] = '{751, 4, 0, 0, 0, 0};
        tab[15] = '{752, 4, 1, 0, 0, 0};
        tab[16] = '{64,  4, 1, 1, 0, 0};
        tab[17] = '{65,  4, 1, 1, 0, 0};
        tab[18] = '{66,  4, 1, 1, 0, 1};
        tab[19] = '{77,  4, 1, 1, 0, 1};
        tab[20] = '{78,  4, 1, 1, 0, 0};
        tab[21] = '{79,  4, 1, 1, 0, 0};
        tab[22] = '{0,   45, 1, 1, 1, 0};
        tab[23] = '{63,  45, 1, 1, 1, 0};
        tab[24] = '{576, 45, 1, 1, 1, 0};
        tab[25] = '{639, 45, 1, 1, 1, 0};
        tab[26] = '{640, 45, 1, 0, 0, 0};
        tab[27] = '{799, 45, 1, 0, 0, 0};

        // Plain glyph: code 0x01, font row 0 = 0x81, everything else blank
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        vram[0] = 8'h01;
        font[8] = 8'h81;

        #2;
        hold_reset();
        apply(0, 15);

        // Random screen and font; inverted glyph in cell 0
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
        vram[0]  = 8'h81;
        font[8]  = 8'h81;
        vram[69] = 8'h2A;
        hold_reset();
        apply(16, 21);

        // Row 2, line 3, column 5 fetch
        run_to(128, 42);
        step();
        check("va_col5", 32'(vram_addr), 32'd69);
        step();
        step();
        check("fa_col5", 32'(font_addr), 32'h153);
        check("va_hold", 32'(vram_addr), 32'd69);

        apply(22, 27);

        // Mid-line reset, then time to first hsync fall
        run_to(300, 46);
        hold_reset();
        n = 0;
        do begin
            step();
            n++;
        end while (hsync !== 1'b0 && n < 2000);
        check("hs_fall", 32'(n), 32'd657);
        repeat (300) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
